// File: rtl/program_loader_if.sv
// Stream, control and IRAM-write signals of the program loader.
// The master modport is the loader side; slave is the host/IRAM side.
interface program_loader_if #(
    parameter int BYTE_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 24,
    parameter int ADDRESS_BUS_WIDTH = 11
);
    logic [BYTE_WIDTH-1:0]        in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         load_request;
    logic [ADDRESS_BUS_WIDTH-1:0] iram_address;
    logic [INSTRUCTION_WIDTH-1:0] iram_write_data;
    logic                         iram_write_enable;
    logic                         cpu_reset;
    logic                         done;
    logic                         error;

    modport master (
        input  in_data, in_valid, load_request,
        output in_ready, iram_address, iram_write_data, iram_write_enable,
               cpu_reset, done, error
    );

    modport slave (
        output in_data, in_valid, load_request,
        input  in_ready, iram_address, iram_write_data, iram_write_enable,
               cpu_reset, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles an MSB-first byte stream into IRAM words from BASE_ADDRESS and holds
// the CPU in reset until the load completes. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module program_loader #(
    parameter int INSTRUCTION_WIDTH = 24,
    parameter int ADDRESS_BUS_WIDTH = 11,
    parameter int BYTE_WIDTH        = 8,
    parameter int BASE_ADDRESS      = 1024,
    parameter int MAX_WORDS         = 1024
) (
    input  logic              clock,
    input  logic              reset,
    program_loader_if.master  bus
);
    localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / BYTE_WIDTH;
    localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int COUNT_W        = 16;

    typedef enum logic [3:0] {
        S_COUNT_HI,
        S_COUNT_LO,
        S_CHECK,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_SUM,
`endif
        S_FINISH,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                       state_q, state_d;
    logic [COUNT_W-1:0]           count_q, count_d;
    logic [COUNT_W-1:0]           index_q, index_d;
    logic [BCNT_W-1:0]            byte_cnt_q, byte_cnt_d;
    logic [INSTRUCTION_WIDTH-1:0] asm_q, asm_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0]        csum_q, csum_d;
`endif

    logic                         in_ready_q, in_ready_d;
    logic                         write_enable_q, write_enable_d;
    logic [ADDRESS_BUS_WIDTH-1:0] address_q, address_d;
    logic [INSTRUCTION_WIDTH-1:0] write_data_q, write_data_d;
    logic                         cpu_reset_q, cpu_reset_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;

    logic                         xfer;

    // Ready is a registered copy of "next state accepts", so in_valid never reaches in_ready.
    function automatic logic accepts(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            S_COUNT_HI, S_COUNT_LO, S_DATA: r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_SUM:                          r = 1'b1;
`endif
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    assign xfer = bus.in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_COUNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = bus.in_data[7:0];
                    state_d       = S_COUNT_LO;
                end
            end
            S_COUNT_LO: begin
                if (xfer) begin
                    count_d[7:0] = bus.in_data[7:0];
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (count_q == '0 || count_q > COUNT_W'(MAX_WORDS)) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d = (asm_q << BYTE_WIDTH) | INSTRUCTION_WIDTH'(bus.in_data);
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    if (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + 1'b1;
                if (index_q == count_q - 1'b1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_SUM;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_SUM: begin
                if (xfer) begin
                    state_d = (bus.in_data == csum_q) ? S_FINISH : S_ERROR;
                end
            end
`endif
            S_FINISH: begin
                state_d = S_RUN;
            end
            S_RUN, S_ERROR: begin
                if (bus.load_request) begin
                    state_d    = S_COUNT_HI;
                    index_d    = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            default: begin
                state_d = S_COUNT_HI;
            end
        endcase

        // Outputs are decoded from the next state and registered alongside it.
        in_ready_d     = accepts(state_d);
        write_enable_d = (state_d == S_WRITE);
        address_d      = address_q;
        write_data_d   = write_data_q;
        if (state_d == S_WRITE) begin
            address_d    = ADDRESS_BUS_WIDTH'(BASE_ADDRESS + int'(index_d));
            write_data_d = asm_d;
        end
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_COUNT_HI;
            count_q        <= '0;
            index_q        <= '0;
            byte_cnt_q     <= '0;
            asm_q          <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
            in_ready_q     <= 1'b0;
            write_enable_q <= 1'b0;
            address_q      <= ADDRESS_BUS_WIDTH'(BASE_ADDRESS);
            write_data_q   <= '0;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            index_q        <= index_d;
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
            in_ready_q     <= in_ready_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            write_data_q   <= write_data_d;
            cpu_reset_q    <= cpu_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign bus.in_ready          = in_ready_q;
    assign bus.iram_write_enable = write_enable_q;
    assign bus.iram_address      = address_q;
    assign bus.iram_write_data   = write_data_q;
    assign bus.cpu_reset         = cpu_reset_q;
    assign bus.done              = done_q;
    assign bus.error             = error_q;
endmodule
